// File: rtl/sha256_pad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pad_pkg
//  Description : Shared types and constants for the SHA-256 message padder.
//  Revision    : 1.0
// ============================================================================
package sha256_pad_pkg;

    localparam int          BLOCK_WORDS = 16;
    localparam int          LEN_SLOT_HI = 14;
    localparam logic [7:0]  PAD_BYTE    = 8'h80;
    localparam logic [31:0] PAD_WORD    = {PAD_BYTE, 24'h000000};

    typedef logic [31:0]                  word_t;
    // Packed so that element 15 lands in [511:480]; slot 0 (first word) is element 15.
    typedef logic [BLOCK_WORDS-1:0][31:0] block_t;

    typedef enum logic [2:0] {
        FILL      = 3'd0,
        PAD       = 3'd1,
        OUT_DATA  = 3'd2,
        OUT_SPILL = 3'd3,
        LEN_BLK   = 3'd4,
        OUT_FINAL = 3'd5
    } state_t;

    function automatic logic [3:0] slot_idx(input logic [3:0] slot);
        return 4'(BLOCK_WORDS - 1) - slot;
    endfunction

endpackage : sha256_pad_pkg
`default_nettype wire

// File: rtl/sha256_pad_word_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_pad_word_gen
//  Description : Masks unused bytes of an input word and inserts the 0x80 pad
//                byte. SHA256_PAD_BYTESWAP_EN selects little-endian input.
//  Revision    : 1.0
// ============================================================================
module sha256_pad_word_gen
    import sha256_pad_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_bytes,
    input  logic        i_last,
    output word_t       o_word,
    output logic [2:0]  o_bytes,
    output logic        o_pad_done
);

    word_t      w_data;
    logic [2:0] w_bytes;

`ifdef SHA256_PAD_BYTESWAP_EN
    assign w_data = {i_data[7:0], i_data[15:8], i_data[23:16], i_data[31:24]};
`else
    assign w_data = i_data;
`endif

    // Partial words only make sense on the final word; anything else counts as full.
    assign w_bytes    = (i_last && (i_bytes < 3'd4)) ? i_bytes : 3'd4;
    assign o_bytes    = w_bytes;
    assign o_pad_done = (w_bytes != 3'd4);

    always_comb begin
        o_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_bytes) begin
                o_word[31-8*k -: 8] = w_data[31-8*k -: 8];
            end else if (3'(k) == w_bytes) begin
                o_word[31-8*k -: 8] = PAD_BYTE;
            end
        end
    end

endmodule : sha256_pad_word_gen
`default_nettype wire

// File: rtl/sha256_message_padder.sv
`default_nettype none
// ============================================================================
//  Module      : sha256_message_padder
//  Description : Packs a 32-bit word stream into FIPS 180-4 padded 512-bit
//                blocks. Option macro: SHA256_PAD_BYTESWAP_EN.
//  Revision    : 1.0
// ============================================================================
module sha256_message_padder
    import sha256_pad_pkg::*;
#(
    parameter int LEN_WIDTH = 64
)
(
    input  logic         HCLK,
    input  logic         HRESETn,
    input  logic [31:0]  in_data,
    input  logic [2:0]   in_bytes,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [511:0] out_block,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready
);

    state_t               r_state;
    logic [4:0]           r_cnt;
    logic [LEN_WIDTH-1:0] r_len;
    block_t               r_block;
    logic                 r_pad_pending;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_out_last;

    word_t                w_word;
    logic [2:0]           w_eff_bytes;
    logic                 w_pad_done;
    logic [LEN_WIDTH-1:0] w_len_inc;
    logic [63:0]          w_len64;
    logic [4:0]           w_pad_slot;
    logic                 w_pad_fits;
    block_t               w_pad_blk;
    block_t               w_len_blk;

    sha256_pad_word_gen u_word_gen (
        .i_data     (in_data),
        .i_bytes    (in_bytes),
        .i_last     (in_last),
        .o_word     (w_word),
        .o_bytes    (w_eff_bytes),
        .o_pad_done (w_pad_done)
    );

    assign w_len_inc = LEN_WIDTH'({w_eff_bytes, 3'b000});
    assign w_len64   = 64'(r_len);

    // Slot holding the 0x80 marker: either still to be written (pending) or
    // already placed inside the last data word.
    assign w_pad_slot = r_pad_pending ? r_cnt : (r_cnt - 5'd1);
    assign w_pad_fits = (w_pad_slot < 5'(LEN_SLOT_HI));

    always_comb begin
        w_pad_blk = r_block;
        for (int i = 0; i < BLOCK_WORDS; i++) begin
            if (5'(i) > w_pad_slot) begin
                w_pad_blk[slot_idx(4'(i))] = '0;
            end else if ((5'(i) == w_pad_slot) && r_pad_pending) begin
                w_pad_blk[slot_idx(4'(i))] = PAD_WORD;
            end
        end
        if (w_pad_fits) begin
            w_pad_blk[slot_idx(4'(LEN_SLOT_HI))]     = w_len64[63:32];
            w_pad_blk[slot_idx(4'(LEN_SLOT_HI + 1))] = w_len64[31:0];
        end
    end

    always_comb begin
        w_len_blk = '0;
        if (r_pad_pending) begin
            w_len_blk[slot_idx(4'd0)] = PAD_WORD;
        end
        w_len_blk[slot_idx(4'(LEN_SLOT_HI))]     = w_len64[63:32];
        w_len_blk[slot_idx(4'(LEN_SLOT_HI + 1))] = w_len64[31:0];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state       <= FILL;
            r_cnt         <= 5'd0;
            r_len         <= '0;
            r_block       <= '0;
            r_pad_pending <= 1'b0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (in_valid) begin
                        r_block[slot_idx(r_cnt[3:0])] <= w_word;
                        r_cnt                         <= r_cnt + 5'd1;
                        r_len                         <= r_len + w_len_inc;
                        if (in_last) begin
                            r_in_ready <= 1'b0;
                            if (w_pad_done) begin
                                r_state <= PAD;
                            end else begin
                                r_pad_pending <= 1'b1;
                                if (r_cnt == 5'd15) begin
                                    r_state     <= OUT_SPILL;
                                    r_out_valid <= 1'b1;
                                end else begin
                                    r_state <= PAD;
                                end
                            end
                        end else if (r_cnt == 5'd15) begin
                            r_state     <= OUT_DATA;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                PAD: begin
                    r_block       <= w_pad_blk;
                    r_pad_pending <= 1'b0;
                    r_out_valid   <= 1'b1;
                    if (w_pad_fits) begin
                        r_state    <= OUT_FINAL;
                        r_out_last <= 1'b1;
                    end else begin
                        r_state <= OUT_SPILL;
                    end
                end
                OUT_DATA: begin
                    if (out_ready) begin
                        r_state     <= FILL;
                        r_cnt       <= 5'd0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                OUT_SPILL: begin
                    if (out_ready) begin
                        r_state     <= LEN_BLK;
                        r_out_valid <= 1'b0;
                    end
                end
                LEN_BLK: begin
                    r_block       <= w_len_blk;
                    r_pad_pending <= 1'b0;
                    r_state       <= OUT_FINAL;
                    r_out_valid   <= 1'b1;
                    r_out_last    <= 1'b1;
                end
                OUT_FINAL: begin
                    if (out_ready) begin
                        r_state       <= FILL;
                        r_cnt         <= 5'd0;
                        r_len         <= '0;
                        r_pad_pending <= 1'b0;
                        r_out_valid   <= 1'b0;
                        r_out_last    <= 1'b0;
                        r_in_ready    <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= FILL;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_block = r_block;

endmodule : sha256_message_padder
`default_nettype wire

// File: tb/tb_sha256_message_padder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha256_message_padder
//  Description : Directed scoreboard bench for sha256_message_padder.
//  Revision    : 1.0
// ============================================================================
module tb_sha256_message_padder;

    logic         clk;
    logic         rst_n;
    logic [31:0]  in_data;
    logic [2:0]   in_bytes;
    logic         in_last;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] out_block;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;

    int checks   = 0;
    int failures = 0;

    logic [511:0] q_blk  [$];
    logic         q_last [$];
    logic [511:0] eb;
    logic [511:0] m_blk;
    logic         m_last;
    logic [511:0] snap;

    sha256_message_padder dut (
        .HCLK      (clk),
        .HRESETn   (rst_n),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_block (out_block),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    task automatic clr_eb();
        eb = '0;
    endtask

    task automatic set_w(input int i, input logic [31:0] v);
        eb[511-32*i -: 32] = v;
    endtask

    task automatic push_exp(input logic last);
        q_blk.push_back(eb);
        q_last.push_back(last);
    endtask

    // Monitor: every accepted block is compared against the queue head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q_blk.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_block act=%h", out_block);
            end else begin
                m_blk  = q_blk.pop_front();
                m_last = q_last.pop_front();
                chk("block", out_block, m_blk);
                chk("out_last", {511'd0, out_last}, {511'd0, m_last});
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic [2:0] b, input logic l);
        int t;
        t        = 0;
        in_data  = d;
        in_bytes = b;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout act=in_ready_low exp=in_ready_high");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input int n_full, input logic [31:0] last_d, input logic [2:0] last_b);
        for (int i = 0; i < n_full; i++) send(pat(i), 3'd4, 1'b0);
        send(last_d, last_b, 1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q_blk.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (q_blk.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout act=%0d pending exp=0", q_blk.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  {511'd0, in_ready},  {511'd0, 1'b1});
        chk({tag, "_out_valid"}, {511'd0, out_valid}, 512'd0);
        chk({tag, "_out_last"},  {511'd0, out_last},  512'd0);
        chk({tag, "_out_block"}, out_block,           512'd0);
    endtask

    task automatic push_abc();
        clr_eb();
        set_w(0, 32'h61626380);
        set_w(15, 32'h00000018);
        push_exp(1'b1);
    endtask

    initial begin
        int t;
        rst_n     = 1'b0;
        in_data   = '0;
        in_bytes  = '0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("rst_rel");

        // Empty message
        clr_eb();
        set_w(0, 32'h80000000);
        push_exp(1'b1);
        send(32'h0, 3'd0, 1'b1);
        drain();

        // "abc"
        push_abc();
        send(32'h61626300, 3'd3, 1'b1);
        drain();

        // "ab" with garbage in unused bytes
        clr_eb();
        set_w(0, 32'h61628000);
        set_w(15, 32'h00000010);
        push_exp(1'b1);
        send(32'h6162FFFF, 3'd2, 1'b1);
        drain();

        // 14 full words, last full: marker in slot 14, length spills
        clr_eb();
        for (int i = 0; i < 14; i++) set_w(i, pat(i));
        set_w(14, 32'h80000000);
        push_exp(1'b0);
        clr_eb();
        set_w(15, 32'h000001C0);
        push_exp(1'b1);
        send_msg(13, pat(13), 3'd4);
        drain();

        // 15 full words: marker in slot 15
        clr_eb();
        for (int i = 0; i < 15; i++) set_w(i, pat(i));
        set_w(15, 32'h80000000);
        push_exp(1'b0);
        clr_eb();
        set_w(15, 32'h000001E0);
        push_exp(1'b1);
        send_msg(14, pat(14), 3'd4);
        drain();

        // 16 full words: marker deferred to the length block
        clr_eb();
        for (int i = 0; i < 16; i++) set_w(i, pat(i));
        push_exp(1'b0);
        clr_eb();
        set_w(0, 32'h80000000);
        set_w(15, 32'h00000200);
        push_exp(1'b1);
        send_msg(15, pat(15), 3'd4);
        drain();

        // 17 full words: second block holds one data word
        clr_eb();
        for (int i = 0; i < 16; i++) set_w(i, pat(i));
        push_exp(1'b0);
        clr_eb();
        set_w(0, pat(16));
        set_w(1, 32'h80000000);
        set_w(15, 32'h00000220);
        push_exp(1'b1);
        send_msg(16, pat(16), 3'd4);
        drain();

        // 15 full + 1-byte last: marker inside slot 15, length block word0 stays 0
        clr_eb();
        for (int i = 0; i < 15; i++) set_w(i, pat(i));
        set_w(15, 32'hBB800000);
        push_exp(1'b0);
        clr_eb();
        set_w(15, 32'h000001E8);
        push_exp(1'b1);
        send_msg(15, 32'hBBCCDDEE, 3'd1);
        drain();

        // 13 full + 3-byte last: marker in slot 13, fits with length
        clr_eb();
        for (int i = 0; i < 13; i++) set_w(i, pat(i));
        set_w(13, 32'h61626380);
        set_w(15, 32'h000001B8);
        push_exp(1'b1);
        send_msg(13, 32'h616263FF, 3'd3);
        drain();

        // Back-pressure in OUT_FINAL
        out_ready = 1'b0;
        push_abc();
        send(32'h61626300, 3'd3, 1'b1);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("stall_valid", {511'd0, out_valid}, {511'd0, 1'b1});
        snap = out_block;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_block", out_block, snap);
            chk("stall_in_ready", {511'd0, in_ready}, 512'd0);
            chk("stall_last", {511'd0, out_last}, {511'd0, 1'b1});
        end
        out_ready = 1'b1;
        drain();

        // Asynchronous reset in the middle of a fill
        for (int i = 0; i < 7; i++) send(pat(i), 3'd4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_abc();
        send(32'h61626300, 3'd3, 1'b1);
        drain();

        repeat (3) @(posedge clk);
        #1;
        chk("idle_valid", {511'd0, out_valid}, 512'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sha256_message_padder
`default_nettype wire
